// File: rtl/mpbuffer_egress_mux.sv
// ---------------------------------------------------------------------------
// mpbuffer_egress_mux
//
// Merges the NoC egress streams of CHANNELS message-passing buffer endpoints
// onto one shared NoC output link. Arbitration is round-robin and
// packet-atomic: once a channel wins, it keeps the link until its last flit
// has been accepted. The output is a single registered slot, so an accepted
// flit appears on out_* one cycle later. The slot can take a new flit in the
// same cycle it is being drained, which keeps full throughput.
//
// Handshake rule for every stream: a beat transfers on a rising clock edge
// where valid and ready are both high. Once valid is raised, it stays high
// and the payload stays stable until that transfer. Ready may depend
// combinationally on valid.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-high reset
//   in_flit         packed input flits, channel i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   in_last         per-channel last-flit marker
//   in_valid        per-channel flit valid
//   in_ready        per-channel flit accepted
//   out_flit        registered output flit
//   out_last        registered last-flit marker
//   out_valid       output slot holds a flit
//   out_ready       downstream accepts the flit
//   active_channel  channel that owns (or last won) the link, debug
//   locked          a multi-flit packet is in progress (state == LOCKED)
// ---------------------------------------------------------------------------
module mpbuffer_egress_mux #(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS*FLIT_WIDTH-1:0]   in_flit,
    input  logic [CHANNELS-1:0]              in_last,
    input  logic [CHANNELS-1:0]              in_valid,
    output logic [CHANNELS-1:0]              in_ready,
    output logic [FLIT_WIDTH-1:0]            out_flit,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(CHANNELS)-1:0]      active_channel,
    output logic                             locked
);

    localparam int CH_W = $clog2(CHANNELS);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                state_q;
    logic [CH_W-1:0]       ptr_q;       // last channel that completed a packet
    logic [CH_W-1:0]       active_q;    // channel owning the link
    logic [FLIT_WIDTH-1:0] out_flit_q;
    logic                  out_last_q;
    logic                  out_valid_q;

    logic                  can_accept;
    logic                  rr_hit;
    logic [CH_W-1:0]       rr_idx;
    logic [CH_W-1:0]       cand;
    logic [CH_W-1:0]       sel_idx;
    logic                  sel_en;
    logic                  xfer;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  sel_last;

    // (base + step) mod CHANNELS. step never exceeds CHANNELS, so one
    // conditional subtraction is enough, also for non-power-of-two counts.
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                                 input int              step);
        int s;
        s = int'(base) + step;
        if (s >= CHANNELS) s = s - CHANNELS;
        return CH_W'(s);
    endfunction

    // The output slot is free if empty or being drained in this cycle.
    assign can_accept = !out_valid_q || out_ready;

    // Round-robin search starting one past the last completed channel.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = wrap_add(ptr_q, k);
            if (!rr_hit && in_valid[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    // Channel selection and input handshake. While LOCKED, ready is offered
    // to the owner whenever the slot is free, independent of its valid.
    // Ready is forced low during reset so nothing transfers before release.
    always_comb begin
        sel_idx  = (state_q == ST_LOCKED) ? active_q : rr_idx;
        sel_en   = !rst && can_accept && ((state_q == ST_LOCKED) || rr_hit);
        in_ready = '0;
        if (sel_en) in_ready[sel_idx] = 1'b1;
        sel_flit = in_flit[int'(sel_idx)*FLIT_WIDTH +: FLIT_WIDTH];
        sel_last = in_last[sel_idx];
        xfer     = sel_en && in_valid[sel_idx];
    end

    // Arbitration state and output slot in one block. A packet in flight at
    // reset is simply abandoned; nothing of it is replayed afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= CH_W'(CHANNELS - 1);
            active_q    <= '0;
            out_flit_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // Output slot: load on accept (possibly while draining, giving
            // back-to-back flits), otherwise empty it when drained.
            if (xfer) begin
                out_flit_q  <= sel_flit;
                out_last_q  <= sel_last;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        active_q <= sel_idx;
                        if (sel_last) begin
                            // Single-flit packet: completes immediately.
                            ptr_q <= sel_idx;
                        end else begin
                            state_q <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (xfer && sel_last) begin
                        ptr_q   <= active_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_flit       = out_flit_q;
    assign out_last       = out_last_q;
    assign out_valid      = out_valid_q;
    assign active_channel = active_q;
    assign locked         = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mpbuffer_egress_mux.sv
module tb_mpbuffer_egress_mux;
  localparam int FW = 32;
  localparam int CH = 3;
  localparam int CW = $clog2(CH);

  logic              clk;
  logic              rst;
  logic [CH*FW-1:0]  in_flit;
  logic [CH-1:0]     in_last;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [FW-1:0]     out_flit;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     active_channel;
  logic              locked;

  mpbuffer_egress_mux #(.FLIT_WIDTH(FW), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .active_channel(active_channel), .locked(locked)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-channel source packets: {last, flit}
  logic [FW:0] src_q [CH][$];
  logic [CH-1:0] acc;            // DUT handshake seen at the last negedge
  // logs of what the DUT did, used by literal checks
  logic [FW:0] got_log[$];
  int          grant_log[$];

  // ---------------- behavioural model ----------------
  // one-slot output buffer, owner of the link (-1 = none), last served channel
  logic [FW:0]   m_buf[$];
  int            m_owner;
  int            m_last;
  logic [CH-1:0] exp_rdy;
  logic          m_can;
  logic          m_found;
  int            m_g;
  logic [CH-1:0] prev_pend;
  logic [FW-1:0] prev_flit [CH];
  logic [FW:0]   m_head;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_locked", 64'(locked), 64'd0);
      chk("rst_active", 64'(active_channel), 64'd0);
      chk("rst_out_flit", 64'(out_flit), 64'd0);
      m_buf.delete();
      m_owner   = -1;
      m_last    = CH - 1;
      acc       = '0;
      prev_pend = '0;
    end else begin
      // input protocol: a pending flit must stay valid and stable
      for (int i = 0; i < CH; i++) begin
        if (prev_pend[i])
          assert (in_valid[i] && in_flit[i*FW +: FW] == prev_flit[i])
            else $error("input stability violated on ch%0d", i);
        prev_pend[i] = in_valid[i] & ~in_ready[i];
        prev_flit[i] = in_flit[i*FW +: FW];
      end

      // expected ready: owner keeps the link, else first valid after last served
      m_can   = (m_buf.size() == 0) || out_ready;
      exp_rdy = '0;
      m_found = 1'b0;
      m_g     = 0;
      if (m_can) begin
        if (m_owner >= 0) begin
          exp_rdy[m_owner] = 1'b1;
          m_g = m_owner;
        end else begin
          for (int k = 1; k <= CH; k++) begin
            if (!m_found && in_valid[(m_last + k) % CH]) begin
              m_found = 1'b1;
              m_g = (m_last + k) % CH;
              exp_rdy[m_g] = 1'b1;
            end
          end
        end
      end

      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(m_buf.size() != 0));
      if (m_buf.size() != 0) begin
        m_head = m_buf[0];
        chk("out_flit", 64'(out_flit), 64'(m_head[FW-1:0]));
        chk("out_last", 64'(out_last), 64'(m_head[FW]));
      end
      chk("locked", 64'(locked), 64'(m_owner >= 0));
      if (m_owner >= 0) chk("active_channel", 64'(active_channel), 64'(m_owner));

      // DUT activity logs and driver feedback
      acc = in_valid & in_ready;
      for (int i = 0; i < CH; i++) if (acc[i]) grant_log.push_back(i);
      if (out_valid && out_ready) got_log.push_back({out_last, out_flit});

      // advance model to the next edge
      if (m_buf.size() != 0 && out_ready) void'(m_buf.pop_front());
      if (|(exp_rdy & in_valid)) begin
        m_buf.push_back({in_last[m_g], in_flit[m_g*FW +: FW]});
        if (in_last[m_g]) begin
          m_last  = m_g;
          m_owner = -1;
        end else begin
          m_owner = m_g;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      in_valid[i] = (src_q[i].size() > 0);
      if (src_q[i].size() > 0) begin
        in_last[i] = src_q[i][0][FW];
        in_flit[i*FW +: FW] = src_q[i][0][FW-1:0];
      end else begin
        in_last[i] = 1'b0;
        in_flit[i*FW +: FW] = '0;
      end
    end
  endtask

  task automatic push(input int ch, input logic last, input logic [FW-1:0] f);
    src_q[ch].push_back({last, f});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < CH; i++) src_q[i].delete();
    in_valid = '0;
    in_last  = '0;
    in_flit  = '0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    chk("async_rst_locked", 64'(locked), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_log.delete();
    grant_log.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    step();
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles", n);
    end
  endtask

  task automatic chk_got(input string nm, input int k, input logic last, input logic [FW-1:0] f);
    if (k < got_log.size()) chk(nm, 64'(got_log[k]), 64'({last, f}));
    else chk({nm, "_missing"}, 64'(got_log.size()), 64'(k + 1));
  endtask

  task automatic chk_grant(input string nm, input int k, input int ch);
    if (k < grant_log.size()) chk(nm, 64'(grant_log[k]), 64'(ch));
    else chk({nm, "_missing"}, 64'(grant_log.size()), 64'(k + 1));
  endtask

  // ---------------- directed tests ----------------
  logic [FW-1:0] hold_flit;

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_flit   = '0;
    out_ready = 1'b1;
    acc       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset then idle
    repeat (4) step();
    do_reset();
    repeat (4) step();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    // 2: 3-flit packet on ch1, then ptr=1 means ch2 beats ch0
    do_reset();
    push(1, 1'b0, 32'hA1);
    push(1, 1'b0, 32'hA2);
    push(1, 1'b1, 32'hA3);
    drain();
    chk("t2_count", 64'(got_log.size()), 64'd3);
    chk_got("t2_f0", 0, 1'b0, 32'hA1);
    chk_got("t2_f1", 1, 1'b0, 32'hA2);
    chk_got("t2_f2", 2, 1'b1, 32'hA3);
    got_log.delete();
    grant_log.delete();
    push(0, 1'b1, 32'hB0);
    push(2, 1'b1, 32'hB2);
    drain();
    chk_grant("t2_ptr_first", 0, 2);
    chk_grant("t2_ptr_second", 1, 0);

    // 3: contention ch0 2-flit vs ch1 1-flit
    do_reset();
    push(0, 1'b0, 32'hC0);
    push(0, 1'b1, 32'hC1);
    push(1, 1'b1, 32'hD0);
    drain();
    chk_got("t3_f0", 0, 1'b0, 32'hC0);
    chk_got("t3_f1", 1, 1'b1, 32'hC1);
    chk_got("t3_f2", 2, 1'b1, 32'hD0);
    chk_grant("t3_g0", 0, 0);
    chk_grant("t3_g1", 1, 0);
    chk_grant("t3_g2", 2, 1);

    // 4: round robin over 3 continuously valid channels
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) push(c, 1'b1, 32'h100 * c + r);
    drain();
    chk("t4_count", 64'(grant_log.size()), 64'd9);
    for (int k = 0; k < 9; k++) begin
      chk_grant("t4_grant", k, k % 3);
      chk_got("t4_flit", k, 1'b1, 32'h100 * (k % 3) + k / 3);
    end

    // 5: backpressure for 5 cycles inside a 4-flit packet
    do_reset();
    push(2, 1'b0, 32'hF0);
    push(2, 1'b0, 32'hF1);
    push(2, 1'b0, 32'hF2);
    push(2, 1'b1, 32'hF3);
    step();
    step();
    out_ready = 1'b0;
    hold_flit = out_flit;
    chk("t5_hold_start", 64'(hold_flit), 64'hF0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_stall_flit", 64'(out_flit), 64'(hold_flit));
      chk("t5_stall_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    drain();
    chk("t5_count", 64'(got_log.size()), 64'd4);
    chk_got("t5_f0", 0, 1'b0, 32'hF0);
    chk_got("t5_f1", 1, 1'b0, 32'hF1);
    chk_got("t5_f2", 2, 1'b0, 32'hF2);
    chk_got("t5_f3", 3, 1'b1, 32'hF3);

    // 6: reset after 2 of 4 flits of ch0, then ch1 single flit
    do_reset();
    push(0, 1'b0, 32'h60);
    push(0, 1'b0, 32'h61);
    push(0, 1'b0, 32'h62);
    push(0, 1'b1, 32'h63);
    for (int k = 0; k < 20 && src_q[0].size() > 2; k++) step();
    chk("t6_pre_reset_valid", 64'(out_valid), 64'd1);
    chk("t6_pre_reset_locked", 64'(locked), 64'd1);
    do_reset();
    push(1, 1'b1, 32'h70);
    drain();
    chk("t6_count", 64'(got_log.size()), 64'd1);
    chk_got("t6_f0", 0, 1'b1, 32'h70);
    chk_grant("t6_g0", 0, 1);
    chk("t6_locked_end", 64'(locked), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mpbuffer_egress_mux.md
Name: mpbuffer_egress_mux

Overview:
- Merges the NoC egress streams of CHANNELS message-passing buffer endpoints onto one shared NoC output link.
- Sits directly downstream of the endpoints' noc_out_* ports and upstream of the router local port.
- Arbitration is packet-atomic and round-robin: once a channel is granted, it owns the link until its last flit transfers.
- The output is registered, with a one-entry buffer, for timing isolation.

Parameters:
- FLIT_WIDTH, 32: width of one flit.
- CHANNELS, 2: number of input streams; legal range 2..8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_flit  in  CHANNELS*FLIT_WIDTH  packed flits; channel i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- in_last  in  CHANNELS  last-flit marker, one bit per channel.
- in_valid  in  CHANNELS  flit valid, one bit per channel.
- in_ready  out  CHANNELS  flit accepted, one bit per channel.
- out_flit  out  FLIT_WIDTH  registered output flit.
- out_last  out  1  registered last-flit marker.
- out_valid  out  1  output holds a flit.
- out_ready  in  1  downstream accepts the flit.
- active_channel  out  clog2(CHANNELS)  index of the channel currently locked; debug use.
- locked  out  1  a packet is in progress.

Behaviour:
- Handshakes:
  - An input transfer occurs when in_valid[i] & in_ready[i].
  - An output transfer occurs when out_valid & out_ready.
  - Once in_valid is raised it must not drop and the flit must not change until the transfer. The bench checks this as an assertion on inputs.
- Output register:
  - Holds one flit.
  - can_accept = !out_valid | out_ready.
  - An accepted flit appears on out_* the next cycle, so latency is 1 cycle.
  - Full throughput is required: one flit per cycle while out_ready stays high.
- State machine, states IDLE and LOCKED:
  - IDLE:
    - If any in_valid is set and can_accept holds, grant the first valid channel searching from (ptr+1) mod CHANNELS upward with wrap.
    - Assert in_ready for that channel only.
    - The flit is transferred in the same cycle.
    - If the transferred flit has in_last set, stay in IDLE and set ptr to the granted index. This is the single-flit packet case.
    - Otherwise go to LOCKED, with active_channel set to the granted index.
  - LOCKED:
    - in_ready[active_channel] = can_accept. All other in_ready bits are 0.
    - When a flit with in_last set transfers from active_channel, set ptr to active_channel and go to IDLE.
    - Other channels' valid flits are ignored while LOCKED.
  - Arbitration is purely combinational on in_valid in IDLE. No grant happens while !can_accept; in_ready stays all 0.
- ptr update:
  - ptr changes only when a packet completes.
  - A packet that has started is never preempted.
  - With all channels continuously valid, grants rotate 0,1,...,CHANNELS-1,0.
- Reset (async assert):
  - State goes to IDLE; ptr goes to CHANNELS-1, so channel 0 wins first.
  - out_valid=0, out_last=0, out_flit=0.
  - in_ready=0, locked=0, active_channel=0.
  - A packet in flight at reset is dropped. No partial flit is reissued after reset.
- Reset deassertion: the first grant may occur in the first clock edge after rst falls.
- Simultaneous events: an output transfer and a new input acceptance in the same cycle must produce back-to-back output flits with no bubble.
- Width rules:
  - active_channel width is clog2(CHANNELS), minimum 1.
  - ptr wraps modulo CHANNELS, including non-power-of-two CHANNELS (for example 3: 2→0).
- locked = (state == LOCKED), registered.
- Flit contents pass through unmodified. No header inspection.

Test Plan:
1. Reset then idle:
   - Stimulus: rst pulse mid-cycle; all in_valid=0.
   - Required: out_valid=0, in_ready=0 immediately on async assert; outputs stay 0 afterwards.
2. Single channel, 3-flit packet on ch1 (0xA1, 0xA2, 0xA3 with last), out_ready=1:
   - Flits appear on consecutive cycles, starting 1 cycle after the first accept.
   - out_last=1 only with 0xA3.
   - Returns to IDLE with ptr=1.
3. Contention, CHANNELS=2:
   - Stimulus: ch0 sends a 2-flit packet and ch1 a 1-flit packet, both valid from the same cycle after reset.
   - Required output order: ch0 flit0, ch0 flit1, ch1 flit.
   - in_ready[1]=0 throughout ch0's packet.
4. Round-robin fairness, CHANNELS=3:
   - Stimulus: all channels hold 1-flit packets continuously for 9 packets.
   - Required grant order: 0,1,2,0,1,2,0,1,2.
5. Backpressure:
   - Stimulus: during a 4-flit packet, out_ready=0 for 5 cycles.
   - Required: out_flit and out_last are stable, in_ready=0, no flit is lost or duplicated; remaining flits resume at full rate.
6. Reset mid-packet:
   - Stimulus: assert rst after 2 of 4 flits of ch0; release; ch1 then sends a 1-flit packet.
   - Required: out_valid drops immediately; ch1's packet is granted; locked=0 after reset.
